// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: the machine word and the mispredict-recovery
// sequencer states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } flush_state_t;

endpackage

// File: rtl/flush_controller.sv
// Mispredict recovery: squash younger stages, drain an in-flight I-cache
// fetch so its stale data is dropped, then redirect the PC to the WB target.
import lc3b_types::*;

module flush_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  lc3b_word         correct_pc,
  input  logic             stall_in,
  input  logic             icache_read,
  input  logic             icache_resp,
  output logic             squash,
  output logic             fetch_hold,
  output logic             discard_resp,
  output logic             pc_redirect_en,
  output lc3b_word         pc_redirect_addr,
  output logic             busy,
  output logic [CNT_W-1:0] flush_count
);

  flush_state_t     r_state;
  flush_state_t     w_state_next;
  lc3b_word         r_target;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;

  // A frozen WB instruction keeps presenting flush, so it is simply re-sampled.
  assign w_accept = (r_state == IDLE) && flush && !stall_in;

  always_comb begin
    squash           = 1'b0;
    fetch_hold       = 1'b0;
    discard_resp     = 1'b0;
    pc_redirect_en   = 1'b0;
    pc_redirect_addr = 16'h0000;
    w_state_next     = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          squash = 1'b1;
          if (icache_read && icache_resp) begin
            discard_resp = 1'b1;
            w_state_next = REDIRECT;
          end else if (icache_read) begin
            w_state_next = DRAIN;
          end else begin
            w_state_next = REDIRECT;
          end
        end
      end
      DRAIN: begin
        squash     = 1'b1;
        fetch_hold = 1'b1;
        if (icache_resp) begin
          discard_resp = 1'b1;
          w_state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        squash           = 1'b1;
        pc_redirect_addr = r_target;
        if (stall_in) begin
          fetch_hold = 1'b1;
        end else begin
          pc_redirect_en = 1'b1;
          w_state_next   = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_target <= 16'h0000;
      r_count  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_target <= correct_pc;
        r_count  <= r_count + 1'b1;
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign flush_count = r_count;

endmodule

// File: doc/flush_controller.md
# flush_controller

Sequences pipeline recovery after a branch/jump misprediction in the five-stage LC-3b pipeline. It accepts the write-back-stage mispredict flush and the correct next PC, squashes younger stages, drains any in-flight instruction-cache fetch so the stale response is discarded, then redirects the PC. It sits between the branch-detection logic in WB, the PC register/mux in IF, and the pipeline-latch valid bits.

## Interface
Parameters:
- CNT_W, 16, width of the flush performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  mispredict detected for the instruction in WB (combinational, from branch detection)
- correct_pc  in  16 (lc3b_word)  architecturally correct next PC, valid with flush
- stall_in  in  1  global pipeline stall (cache miss in MEM/IF); freezes the WB instruction
- icache_read  in  1  IF has an I-cache read outstanding this cycle
- icache_resp  in  1  I-cache returns data this cycle
- squash  out  1  clear valid bits of IF/ID, ID/EX, EX/MEM at the next edge
- fetch_hold  out  1  IF must not launch a new I-cache read
- discard_resp  out  1  IF must drop the I-cache data returned this cycle
- pc_redirect_en  out  1  load PC from pc_redirect_addr at the next edge
- pc_redirect_addr  out  16 (lc3b_word)  redirect target
- busy  out  1  state != IDLE
- flush_count  out  CNT_W  number of accepted flushes, wraps

## Operation
- States: IDLE, DRAIN, REDIRECT. Reset: IDLE; target_reg = 16'h0000; flush_count = 0; all outputs 0 (pc_redirect_addr = 0).
- IDLE: flush accepted iff flush & !stall_in. On accept: squash=1 (Mealy, same cycle), target_reg <= correct_pc, flush_count += 1. Next state DRAIN if icache_read & !icache_resp, else REDIRECT. flush with stall_in=1 is not accepted; re-sampled each cycle while WB is frozen.
- DRAIN: squash=1, fetch_hold=1. When icache_resp=1: discard_resp=1, next REDIRECT. Otherwise remain.
- REDIRECT: pc_redirect_addr = target_reg. If !stall_in: pc_redirect_en=1, squash=1, next IDLE. If stall_in: pc_redirect_en=0, squash=1, fetch_hold=1, remain.
- fetch_hold=1 in DRAIN and in stalled REDIRECT; 0 in IDLE and unstalled REDIRECT.
- flush asserted in DRAIN or REDIRECT is ignored (it can only originate from an instruction already squashed); not counted.
- Accept cycle with icache_read & icache_resp both 1: the response belongs to the wrong path; discard_resp=1 that cycle, next REDIRECT.
- flush_count wraps modulo 2^CNT_W.
- rst asserted mid-sequence: immediately IDLE, all outputs 0, in-flight target lost.

## Timing
- Best case (no outstanding fetch, no stall): flush at cycle N -> squash at N, pc_redirect_en at N+1, correct-path fetch at N+2.
- Outstanding fetch resolving at cycle N+k: DRAIN occupies N+1..N+k, REDIRECT at N+k+1.
- Outputs are combinational from state and inputs; only state, target_reg, and flush_count are registered.
- No combinational path from flush to pc_redirect_en.

## Structure
- The state enum flush_state_t (IDLE/DRAIN/REDIRECT) goes in lc3b_types, alongside lc3b_word.
- Single module with no sub-modules; the counter is inline.

## Test plan
- Simple mispredict: flush=1, correct_pc=16'h3042, icache idle -> squash at N; pc_redirect_en=1, addr=16'h3042 at N+1; busy=0 at N+2; flush_count=1.
- Outstanding miss: flush with icache_read=1, icache_resp=0, resp arrives 5 cycles later -> fetch_hold=1 for 5 cycles, discard_resp=1 on the resp cycle, redirect on the following cycle.
- Stall interplay: flush with stall_in=1 for 3 cycles -> no accept and count unchanged until stall drops; stall during REDIRECT -> pc_redirect_en held 0 until release, address stable.
- Spurious flush in DRAIN: assert flush with correct_pc=16'h1111 -> target stays original and count increments once.
- Reset mid-DRAIN: rst pulse -> all outputs 0, state IDLE, count 0, next flush handled normally.
- Counter wrap with CNT_W=4: 17 flushes -> flush_count=1.
